soft_pull_sampler: RTL and testbench

Multi-channel emulated pull resistor for FPGA pads without usable internal pulls. Each frame it briefly drives every pad to its configured idle level (low = pull-down, high = pull-up), releases, waits for the pad to settle, then samples once. The sampled value passes through a per-channel consecutive-sample filter. The block sits directly behind bidirectional top-level switch/button pins and feeds clean levels and change pulses into the core.

---
 rtl/soft_pull_pkg.sv | 16 +
 rtl/pull_glitch_filter.sv | 47 ++++
 rtl/soft_pull_sampler.sv | 109 ++++++++++
 tb/tb_soft_pull_sampler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/soft_pull_pkg.sv
// Shared types and helpers for the emulated pull-resistor sampler.
// Frame phases and the phase decode used by the top-level sequencer.
package soft_pull_pkg;

  typedef enum logic [1:0] {PH_DRIVE, PH_SETTLE, PH_SAMPLE, PH_IDLE} pull_phase_e;

  function automatic pull_phase_e phase_of(input int ph, input int drive_cycles, input int s);
    pull_phase_e p;
    if (ph < drive_cycles)   p = PH_DRIVE;
    else if (ph < s)         p = PH_SETTLE;
    else if (ph == s)        p = PH_SAMPLE;
    else                     p = PH_IDLE;
    return p;
  endfunction

endpackage

// File: rtl/pull_glitch_filter.sv
// One channel of the consecutive-sample filter: out flips only after
// FILTER back-to-back samples disagree with it.
module pull_glitch_filter #(
  parameter int FILTER = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_en,
  input  logic din,
  output logic out,
  output logic changed
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_FLIP = CW'(FILTER);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  // Any agreeing sample restarts the count, so only an unbroken run flips out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      out     <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (sample_en) begin
        if (din == out) begin
          cnt <= '0;
        end else if (cnt_inc == CNT_FLIP) begin
          out     <= ~out;
          changed <= 1'b1;
          cnt     <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/soft_pull_sampler.sv
// Emulated pull resistors: each frame drive pads to their idle level, release,
// let them settle, sample through a synchronizer and filter per channel.
module soft_pull_sampler
  import soft_pull_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int PERIOD        = 16,
  parameter int DRIVE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int FILTER        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] pins,
  input  logic [WIDTH-1:0] pull_up,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] changed,
  output logic             sample_valid
);

  localparam int S  = DRIVE_CYCLES + SETTLE_CYCLES;
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("soft_pull_sampler: WIDTH must be >= 1");
    end
    if (DRIVE_CYCLES < 1) begin : g_bad_drive
      $error("soft_pull_sampler: DRIVE_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("soft_pull_sampler: SETTLE_CYCLES must be >= 3");
    end
    if (PERIOD <= S) begin : g_bad_period
      $error("soft_pull_sampler: PERIOD must exceed DRIVE_CYCLES + SETTLE_CYCLES");
    end
    if (FILTER < 1) begin : g_bad_filter
      $error("soft_pull_sampler: FILTER must be >= 1");
    end
  endgenerate

  logic [PW-1:0]    ph;
  pull_phase_e      phase;
  logic             drive;
  logic             sample_en;
  logic             clear;
  logic [WIDTH-1:0] pull_lat;
  logic [WIDTH-1:0] pin_m;
  logic [WIDTH-1:0] pin_s;

  // Gating with rst_n releases the pads the instant reset asserts.
  always_comb begin
    phase     = phase_of(int'(ph), DRIVE_CYCLES, S);
    drive     = rst_n && enable && (phase == PH_DRIVE);
    sample_en = enable && (phase == PH_SAMPLE);
    clear     = ~enable;
  end

  assign pins = drive ? pull_lat : {WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else if (!enable) begin
      ph <= '0;
    end else if (ph == PH_LAST) begin
      ph <= '0;
    end else begin
      ph <= ph + PW'(1);
    end
  end

  // Tracking pull_up while disabled means the first frame after enable
  // already drives the current polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pull_lat <= '0;
    end else if (!enable || ph == PH_LAST) begin
      pull_lat <= pull_up;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_m        <= '0;
      pin_s        <= '0;
      sample_valid <= 1'b0;
    end else begin
      pin_m        <= pins;
      pin_s        <= pin_m;
      sample_valid <= sample_en;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pull_glitch_filter #(.FILTER(FILTER)) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .sample_en(sample_en),
      .din      (pin_s[i]),
      .out      (out[i]),
      .changed  (changed[i])
    );
  end

endmodule

// File: tb/tb_soft_pull_sampler.sv
// Directed bench for soft_pull_sampler: a FILTER=3 two-channel instance with a
// weak-keeper pad model, plus a FILTER=1 single-channel instance forced high.
module tb_soft_pull_sampler;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] eOut;
    logic [1:0] eChg;
    logic       eValid;
    logic       eOut2;
    logic       eChg2;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pullUp = 2'b01;

  wire  [1:0] pins;
  wire  [0:0] pins2;
  logic [1:0] out;
  logic [1:0] changed;
  logic       sampleValid;
  logic [0:0] out2;
  logic [0:0] changed2;
  logic       sampleValid2;

  logic [3:0] tbPh     = '0;
  logic [1:0] keeper   = '0;
  logic [1:0] forceEn  = '0;
  logic [1:0] forceVal = '0;
  logic       modelDrive;

  int n           = 0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  soft_pull_sampler #(
    .WIDTH(2), .PERIOD(16), .DRIVE_CYCLES(1), .SETTLE_CYCLES(4), .FILTER(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pins(pins), .pull_up(pullUp), .enable(enable),
    .out(out), .changed(changed), .sample_valid(sampleValid)
  );

  soft_pull_sampler #(
    .WIDTH(1), .PERIOD(16), .DRIVE_CYCLES(1), .SETTLE_CYCLES(4), .FILTER(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .pins(pins2), .pull_up(1'b0), .enable(enable),
    .out(out2), .changed(changed2), .sample_valid(sampleValid2)
  );

  // Board model: the pad is only DUT-driven in phase 0 of a running frame;
  // otherwise the external force or the keeper (last driven level) holds it.
  assign modelDrive = rst_n && enable && (tbPh == 4'd0);
  assign pins  = modelDrive ? 2'bzz : ((forceEn & forceVal) | (~forceEn & keeper));
  assign pins2 = modelDrive ? 1'bz : 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             tbPh <= '0;
    else if (!enable)       tbPh <= '0;
    else if (tbPh == 4'd15) tbPh <= '0;
    else                    tbPh <= tbPh + 4'd1;
  end

  always @(posedge clk) begin
    if (modelDrive) keeper <= pins;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [7:0] got;
    logic [7:0] exp;
    got = {out, changed, sampleValid, out2, changed2, sampleValid2};
    exp = {v.eOut, v.eChg, v.eValid, v.eOut2, v.eChg2, v.eValid};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s n=%0d: out/chg/vld/out2/chg2/vld2 got %b required %b",
               v.name, n, got, exp);
    end
  endtask

  task automatic checkPins(input string name, input logic [1:0] exp);
    vectors++;
    if (pins !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s n=%0d: pins got %b required %b", name, n, pins, exp);
    end
  endtask

  task automatic toCycle(input int target);
    while (n < target) tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    toCycle(v.cyc);
    checkOutput(v);
  endtask

  task automatic expectAt(input int cyc, input string name, input logic [1:0] eo,
                          input logic [1:0] ec, input logic ev, input logic eo2,
                          input logic ec2);
    vec_t v;
    v.cyc = cyc; v.name = name; v.eOut = eo; v.eChg = ec;
    v.eValid = ev; v.eOut2 = eo2; v.eChg2 = ec2;
    applyStimulus(v);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rstVec;

    // First three frames with pull_up=01 and floating pads: bit 0 flips after
    // three samples (ph 5 of frames 1..3), visible at cycle 38.
    tbl[0] = '{5,  "f1ph5",  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{6,  "f1ph6",  2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{7,  "f1ph7",  2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{22, "f2ph6",  2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{37, "f3ph5",  2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{38, "f3flip", 2'b01, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{39, "f3ph7",  2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{54, "f4ph6",  2'b01, 2'b00, 1'b1, 1'b1, 1'b0};
    rstVec = '{0, "reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    $display("[TB] start");
    tick();
    tick();
    checkOutput(rstVec);
    rst_n = 1'b1;
    tick();
    tick();

    enable = 1'b1;
    n = 0;
    #1;
    checkPins("firstDrive", 2'b01);
    for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

    // Bit 0 forced low for two frames only: count builds then clears.
    toCycle(64);
    forceEn = 2'b01; forceVal = 2'b00;
    expectAt(70,  "bounceF5", 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    expectAt(86,  "bounceF6", 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    toCycle(96);
    forceEn = 2'b00;
    expectAt(102, "bounceRel", 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);

    // Forced low for three frames: bit 0 falls at frame 10.
    toCycle(112);
    forceEn = 2'b01;
    expectAt(134, "holdF9",   2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    expectAt(149, "holdPre",  2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    expectAt(150, "holdFlip", 2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
    expectAt(151, "holdPost", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    toCycle(160);
    forceEn = 2'b00;
    #1;
    checkPins("driveF11", 2'b01);

    // pull_up changed mid-frame: polarity switches at the next frame only.
    toCycle(167);
    pullUp = 2'b10;
    toCycle(176);
    checkPins("polarityF12", 2'b10);
    expectAt(198, "polF13",  2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    expectAt(214, "polFlip", 2'b10, 2'b10, 1'b1, 1'b1, 1'b0);

    // Both bits disagree for two samples, then enable drops on SAMPLE.
    toCycle(215);
    pullUp = 2'b01;
    toCycle(224);
    checkPins("driveF15", 2'b01);
    toCycle(261);
    enable = 1'b0;
    expectAt(262, "dropSample", 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    enable = 1'b1;
    n = 0;
    #1;
    checkPins("reenDrive", 2'b01);
    expectAt(6,  "reenF1", 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
    expectAt(22, "reenF2", 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
    expectAt(38, "reenF3", 2'b01, 2'b11, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset during DRIVE.
    toCycle(48);
    rst_n = 1'b0;
    forceEn = 2'b11; forceVal = 2'b00;
    #1;
    checkOutput(rstVec);
    checkPins("resetRelease", 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    forceEn = 2'b00;
    n = 0;
    expectAt(5, "rstRestart5", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    expectAt(6, "rstRestart6", 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
